// File: rtl/tile_pkg.sv
// -----------------------------------------------------------------------------
// tile_pkg
// Shared types and defaults for the falling-tile lane tracker.
//   game_state_t : game FSM encoding (IDLE / PLAY / OVER)
//   Y_W          : width of a tile-top y coordinate
//   *_DEF        : default slot depth, hit-zone bounds, miss line, miss limit
//   sat_add_y    : y + speed, clamped at the all-ones coordinate
// -----------------------------------------------------------------------------
package tile_pkg;

    localparam int Y_W = 10;

    localparam int             DEPTH_DEF    = 4;
    localparam logic [Y_W-1:0] HIT_TOP_DEF  = 10'd400;
    localparam logic [Y_W-1:0] HIT_BOT_DEF  = 10'd440;
    localparam logic [Y_W-1:0] MISS_Y_DEF   = 10'd460;
    localparam logic [3:0]     MAX_MISS_DEF = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

    function automatic logic [Y_W-1:0] sat_add_y(input logic [Y_W-1:0] y,
                                                  input logic [3:0]     inc);
        logic [Y_W:0] sum;
        sum = {1'b0, y} + {{(Y_W-3){1'b0}}, inc};
        return sum[Y_W] ? {Y_W{1'b1}} : sum[Y_W-1:0];
    endfunction

endpackage

// File: rtl/tile_lane.sv
// -----------------------------------------------------------------------------
// tile_lane
// One lane of falling tiles: an ordered slot FIFO (slot 0 = oldest), per-frame
// advance, hit-zone judgement of the oldest tile and a kill-key synchronizer
// with rising-edge detect.
// Optional feature macro: TILE_MISS_PENALTY_EN -- a key press that does not
// land on an in-zone oldest tile is reported as a miss (tile is kept).
// Ports:
//   i_clk, i_srst   clock, synchronous active-high reset
//   i_en            lane accepts spawn/tick/kill (game in PLAY)
//   i_clear         empty all slots (game in IDLE)
//   i_tick          one-cycle frame pulse
//   i_spawn         one-cycle spawn pulse
//   i_kill          key level, asynchronous
//   i_speed         pixels added per frame
//   o_y, o_valid    registered slot contents, slot S at [S*Y_W +: Y_W]
//   o_hit, o_miss   combinational per-cycle judgement events (already gated
//                   by i_en); the parent registers them
// -----------------------------------------------------------------------------
module tile_lane
    import tile_pkg::*;
#(
    parameter int             DEPTH   = DEPTH_DEF,
    parameter logic [Y_W-1:0] HIT_TOP = HIT_TOP_DEF,
    parameter logic [Y_W-1:0] HIT_BOT = HIT_BOT_DEF,
    parameter logic [Y_W-1:0] MISS_Y  = MISS_Y_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_srst,
    input  logic                 i_en,
    input  logic                 i_clear,
    input  logic                 i_tick,
    input  logic                 i_spawn,
    input  logic                 i_kill,
    input  logic [3:0]           i_speed,
    output logic [DEPTH*Y_W-1:0] o_y,
    output logic [DEPTH-1:0]     o_valid,
    output logic                 o_hit,
    output logic                 o_miss
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [Y_W-1:0] r_y [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic r_sync1, r_sync2, r_kill_prev;

    logic [Y_W-1:0]   w_adv_y  [DEPTH];
    logic [Y_W-1:0]   w_next_y [DEPTH];
    logic [DEPTH-1:0] w_next_v;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_push_idx;
    logic w_kill_edge, w_do_tick, w_in_zone, w_hit, w_tick_miss;
    logic w_pop, w_full, w_push, w_drop, w_penalty;

    assign w_kill_edge = r_sync2 & ~r_kill_prev;
    assign w_do_tick   = i_en & i_tick;

    // Judged on the pre-tick position of the oldest tile.
    assign w_in_zone = r_valid[0] && (r_y[0] >= HIT_TOP) && (r_y[0] <= HIT_BOT);
    assign w_hit     = i_en & w_kill_edge & w_in_zone;

    // A hit already removes the oldest tile; the new oldest is not checked
    // until the next tick.
    assign w_tick_miss = w_do_tick & r_valid[0] & ~w_hit & (w_adv_y[0] >= MISS_Y);

    assign w_pop  = w_hit | w_tick_miss;
    assign w_full = r_valid[DEPTH-1];
    assign w_push = i_en & i_spawn & (~w_full | w_pop);
    assign w_drop = i_en & i_spawn & w_full & ~w_pop;

`ifdef TILE_MISS_PENALTY_EN
    assign w_penalty = i_en & w_kill_edge & ~w_in_zone;
`else
    assign w_penalty = 1'b0;
`endif

    assign o_hit  = w_hit;
    assign o_miss = w_tick_miss | w_drop | w_penalty;

    // Slots fill contiguously from 0, so occupancy is a popcount.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + CNT_W'(r_valid[i]);
        end
    end

    assign w_push_idx = w_count - CNT_W'(w_pop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign w_adv_y[gi] = (w_do_tick && r_valid[gi]) ? sat_add_y(r_y[gi], i_speed)
                                                            : r_y[gi];

            logic [Y_W-1:0] w_up_y;
            logic           w_up_v;
            if (gi == DEPTH-1) begin : g_last
                assign w_up_y = '0;
                assign w_up_v = 1'b0;
            end else begin : g_mid
                assign w_up_y = w_adv_y[gi+1];
                assign w_up_v = r_valid[gi+1];
            end

            // Shift on pop, then drop the freshly spawned tile (y=0, not
            // advanced this cycle) into the first free slot.
            always_comb begin
                w_next_y[gi] = w_pop ? w_up_y : w_adv_y[gi];
                w_next_v[gi] = w_pop ? w_up_v : r_valid[gi];
                if (w_push && (w_push_idx == CNT_W'(gi))) begin
                    w_next_y[gi] = '0;
                    w_next_v[gi] = 1'b1;
                end
            end

            assign o_y[gi*Y_W +: Y_W] = r_y[gi];
        end
    endgenerate

    assign o_valid = r_valid;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_kill_prev <= 1'b0;
            r_valid     <= '0;
            for (int i = 0; i < DEPTH; i++) r_y[i] <= '0;
        end else begin
            r_sync1     <= i_kill;
            r_sync2     <= r_sync1;
            r_kill_prev <= r_sync2;
            if (i_clear) begin
                r_valid <= '0;
                for (int i = 0; i < DEPTH; i++) r_y[i] <= '0;
            end else if (i_en) begin
                r_valid <= w_next_v;
                for (int i = 0; i < DEPTH; i++) r_y[i] <= w_next_v[i] ? w_next_y[i] : '0;
            end
        end
    end

endmodule

// File: rtl/tile_lane_tracker.sv
// -----------------------------------------------------------------------------
// tile_lane_tracker
// Four lanes of falling tiles with game FSM (IDLE/PLAY/OVER), hit score and
// miss counter. Optional feature macro: TILE_MISS_PENALTY_EN (see tile_lane).
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   frame_tick            one-cycle pulse per video frame
//   screen                1 = title screen, forces IDLE
//   block1..block4        one-cycle spawn pulses per lane
//   kill1..kill4          asynchronous key levels per lane
//   speed                 pixels per frame
//   tile_y, tile_valid    lane L slot S at [(L*DEPTH+S)*10 +: 10] / [L*DEPTH+S]
//   hit_pulse, miss_pulse per-lane one-cycle judgement pulses
//   score, misses         saturating hit / miss counters
//   game_over             high while in OVER
// -----------------------------------------------------------------------------
module tile_lane_tracker
    import tile_pkg::*;
#(
    parameter int         DEPTH    = DEPTH_DEF,
    parameter logic [9:0] HIT_TOP  = HIT_TOP_DEF,
    parameter logic [9:0] HIT_BOT  = HIT_BOT_DEF,
    parameter logic [9:0] MISS_Y   = MISS_Y_DEF,
    parameter logic [3:0] MAX_MISS = MAX_MISS_DEF
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_tick,
    input  logic                     screen,
    input  logic                     block1,
    input  logic                     block2,
    input  logic                     block3,
    input  logic                     block4,
    input  logic                     kill1,
    input  logic                     kill2,
    input  logic                     kill3,
    input  logic                     kill4,
    input  logic [3:0]               speed,
    output logic [4*DEPTH*Y_W-1:0]   tile_y,
    output logic [4*DEPTH-1:0]       tile_valid,
    output logic [3:0]               hit_pulse,
    output logic [3:0]               miss_pulse,
    output logic [15:0]              score,
    output logic [3:0]               misses,
    output logic                     game_over
);

    game_state_t r_state, w_state_next;
    logic [3:0]  r_hit_pulse, r_miss_pulse;
    logic [15:0] r_score;
    logic [3:0]  r_misses;
    logic        r_game_over;

    logic [3:0]  w_block, w_kill, w_hit, w_miss;
    logic [2:0]  w_hit_cnt, w_miss_cnt;
    logic [16:0] w_score_sum;
    logic [4:0]  w_miss_sum;
    logic        w_en, w_clear;

    assign w_block = {block4, block3, block2, block1};
    assign w_kill  = {kill4, kill3, kill2, kill1};
    assign w_en    = (r_state == ST_PLAY);
    assign w_clear = (r_state == ST_IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            tile_lane #(
                .DEPTH   (DEPTH),
                .HIT_TOP (HIT_TOP),
                .HIT_BOT (HIT_BOT),
                .MISS_Y  (MISS_Y)
            ) u_lane (
                .i_clk   (Clk),
                .i_srst  (Reset),
                .i_en    (w_en),
                .i_clear (w_clear),
                .i_tick  (frame_tick),
                .i_spawn (w_block[gi]),
                .i_kill  (w_kill[gi]),
                .i_speed (speed),
                .o_y     (tile_y[gi*DEPTH*Y_W +: DEPTH*Y_W]),
                .o_valid (tile_valid[gi*DEPTH +: DEPTH]),
                .o_hit   (w_hit[gi]),
                .o_miss  (w_miss[gi])
            );
        end
    endgenerate

    always_comb begin
        w_hit_cnt  = '0;
        w_miss_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            w_hit_cnt  = w_hit_cnt  + 3'(w_hit[i]);
            w_miss_cnt = w_miss_cnt + 3'(w_miss[i]);
        end
    end

    assign w_score_sum = {1'b0, r_score} + 17'(w_hit_cnt);
    assign w_miss_sum  = {1'b0, r_misses} + 5'(w_miss_cnt);

    // The OVER decision uses the registered miss count, so the game ends the
    // cycle after the count reaches the limit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: w_state_next = ST_PLAY;
            ST_PLAY: if (r_misses >= MAX_MISS) w_state_next = ST_OVER;
            ST_OVER: w_state_next = ST_OVER;
            default: w_state_next = ST_IDLE;
        endcase
        if (screen) w_state_next = ST_IDLE;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_hit_pulse  <= '0;
            r_miss_pulse <= '0;
            r_score      <= '0;
            r_misses     <= '0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_game_over  <= (w_state_next == ST_OVER);
            r_hit_pulse  <= w_hit;
            r_miss_pulse <= w_miss;
            if (r_state == ST_IDLE) begin
                r_score  <= '0;
                r_misses <= '0;
            end else if (r_state == ST_PLAY) begin
                r_score  <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
                r_misses <= (w_miss_sum >= {1'b0, MAX_MISS}) ? MAX_MISS : w_miss_sum[3:0];
            end
        end
    end

    assign hit_pulse  = r_hit_pulse;
    assign miss_pulse = r_miss_pulse;
    assign score      = r_score;
    assign misses     = r_misses;
    assign game_over  = r_game_over;

endmodule

// File: tb/tb_tile_lane_tracker.sv
// -----------------------------------------------------------------------------
// tb_tile_lane_tracker
// Self-checking bench: a queue-based game model is stepped on every clock edge
// and compared against all DUT outputs; directed tables and sequences check
// the hit zone, miss line, overflow, multi-lane miss, held keys and restart.
// -----------------------------------------------------------------------------
module tb_tile_lane_tracker;

    localparam int DEPTH = 4;
    localparam int YW    = 10;
    localparam int MAXM  = 3;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic frame_tick = 1'b0;
    logic screen = 1'b1;
    logic [3:0] blk = '0;
    logic [3:0] kil = '0;
    logic [3:0] speed = '0;

    logic [4*DEPTH*YW-1:0] tile_y;
    logic [4*DEPTH-1:0]    tile_valid;
    logic [3:0]            hit_pulse, miss_pulse;
    logic [15:0]           score;
    logic [3:0]            misses;
    logic                  game_over;

    always #5 Clk = ~Clk;

    tile_lane_tracker dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .screen     (screen),
        .block1     (blk[0]),
        .block2     (blk[1]),
        .block3     (blk[2]),
        .block4     (blk[3]),
        .kill1      (kil[0]),
        .kill2      (kil[1]),
        .kill3      (kil[2]),
        .kill4      (kil[3]),
        .speed      (speed),
        .tile_y     (tile_y),
        .tile_valid (tile_valid),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score),
        .misses     (misses),
        .game_over  (game_over)
    );

`ifdef TILE_MISS_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    int         m_q [4][$];
    int         m_state = 0;      // 0 idle, 1 play, 2 over
    int         m_score = 0;
    int         m_misses = 0;
    logic [3:0] m_hitp = '0, m_missp = '0;
    logic       m_go = 1'b0;
    logic [3:0] kh1 = '0, kh2 = '0, kh3 = '0;   // key samples 1,2,3 edges ago

    task automatic model_step();
        logic [3:0] edg, hits, mv;
        int nstate;
        if (Reset) begin
            for (int l = 0; l < 4; l++) m_q[l].delete();
            m_state = 0; m_score = 0; m_misses = 0;
            m_hitp = '0; m_missp = '0; m_go = 1'b0;
            kh1 = '0; kh2 = '0; kh3 = '0;
            return;
        end
        // A key press is judged two edges after its rise is first sampled.
        edg = kh2 & ~kh3;
        kh3 = kh2; kh2 = kh1; kh1 = kil;
        hits = '0; mv = '0;
        if (m_state == 1) begin
            for (int l = 0; l < 4; l++) begin
                bit h;
                h = edg[l] && m_q[l].size() > 0 && m_q[l][0] >= 400 && m_q[l][0] <= 440;
                if (frame_tick)
                    for (int i = 0; i < m_q[l].size(); i++)
                        m_q[l][i] = (m_q[l][i] + int'(speed) > 1023) ? 1023 : m_q[l][i] + int'(speed);
                if (h) begin
                    void'(m_q[l].pop_front());
                    hits[l] = 1'b1;
                end else if (frame_tick && m_q[l].size() > 0 && m_q[l][0] >= 460) begin
                    void'(m_q[l].pop_front());
                    mv[l] = 1'b1;
                end
                if (blk[l]) begin
                    if (m_q[l].size() < DEPTH) m_q[l].push_back(0);
                    else mv[l] = 1'b1;
                end
                if (PEN != 0 && edg[l] && !h) mv[l] = 1'b1;
            end
        end else if (m_state == 0) begin
            for (int l = 0; l < 4; l++) m_q[l].delete();
        end
        if (screen) nstate = 0;
        else if (m_state == 0) nstate = 1;
        else if (m_state == 1) nstate = (m_misses >= MAXM) ? 2 : 1;
        else nstate = 2;
        if (m_state == 0) begin
            m_score = 0; m_misses = 0;
        end else if (m_state == 1) begin
            m_score  = m_score + $countones(hits);
            if (m_score > 65535) m_score = 65535;
            m_misses = m_misses + $countones(mv);
            if (m_misses > MAXM) m_misses = MAXM;
        end
        m_hitp = hits; m_missp = mv;
        m_go = (nstate == 2);
        m_state = nstate;
    endtask

    task automatic check_all();
        logic [4*DEPTH*YW-1:0] ey;
        logic [4*DEPTH-1:0]    ev;
        ey = '0; ev = '0;
        for (int l = 0; l < 4; l++)
            for (int s = 0; s < m_q[l].size(); s++) begin
                ey[(l*DEPTH+s)*YW +: YW] = YW'(m_q[l][s]);
                ev[l*DEPTH+s] = 1'b1;
            end
        n_checks++;
        if (tile_y === ey && tile_valid === ev && hit_pulse === m_hitp &&
            miss_pulse === m_missp && score === 16'(m_score) &&
            misses === 4'(m_misses) && game_over === m_go)
            n_pass++;
        else
            $display("FAIL model t=%0t: got y=%h v=%h hit=%b miss=%b score=%0d misses=%0d go=%b, expected y=%h v=%h hit=%b miss=%b score=%0d misses=%0d go=%b",
                     $time, tile_y, tile_valid, hit_pulse, miss_pulse, score, misses, game_over,
                     ey, ev, m_hitp, m_missp, m_score, m_misses, m_go);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clock: model and DUT see the same inputs, then outputs are compared
    // 1 time unit after the edge; single-cycle pulses are then released.
    task automatic cycle();
        @(posedge Clk);
        model_step();
        #1;
        check_all();
        frame_tick = 1'b0;
        blk = '0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cycle();
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1; screen = 1'b1; kil = '0; blk = '0; frame_tick = 1'b0;
        cycle();
        cycle();
        Reset = 1'b0;
    endtask

    task automatic start_play();
        screen = 1'b0;
        cycle();
    endtask

    typedef struct {
        int spd;
        int nticks;
        int exp_y;
        int exp_hit;
    } vec_t;

    vec_t vecs [7];
    int   cnt;

    initial begin
        vecs[0] = '{4, 100, 400, 1};
        vecs[1] = '{4,  99, 396, 0};
        vecs[2] = '{8,  55, 440, 1};
        vecs[3] = '{3, 147, 441, 0};
        vecs[4] = '{10, 40, 400, 1};
        vecs[5] = '{13, 34, 442, 0};
        vecs[6] = '{7,  62, 434, 1};

        // Reset state
        do_reset();
        chk("reset_valid", int'(tile_valid), 0);
        chk("reset_y_any", int'(|tile_y), 0);
        chk("reset_score", int'(score), 0);
        chk("reset_misses", int'(misses), 0);
        chk("reset_pulses", int'({hit_pulse, miss_pulse}), 0);
        chk("reset_game_over", int'(game_over), 0);

        // Hit-zone table on lane 1
        for (int v = 0; v < 7; v++) begin
            do_reset();
            start_play();
            blk[0] = 1'b1;
            cycle();
            speed = 4'(vecs[v].spd);
            ticks(vecs[v].nticks);
            chk($sformatf("zone%0d_y", v), int'(tile_y[9:0]), vecs[v].exp_y);
            kil[0] = 1'b1;
            cycle();
            cycle();
            chk($sformatf("zone%0d_early_hit", v), int'(hit_pulse[0]), 0);
            cycle();
            chk($sformatf("zone%0d_hit", v), int'(hit_pulse[0]), vecs[v].exp_hit);
            chk($sformatf("zone%0d_score", v), int'(score), vecs[v].exp_hit);
            chk($sformatf("zone%0d_valid", v), int'(tile_valid[0]), 1 - vecs[v].exp_hit);
            kil[0] = 1'b0;
            cycle();
        end

        // Miss line on lane 2
        do_reset();
        start_play();
        blk[1] = 1'b1;
        cycle();
        speed = 4'd5;
        ticks(91);
        chk("miss_pre_y", int'(tile_y[49:40]), 455);
        chk("miss_pre_pulse", int'(miss_pulse), 0);
        ticks(1);
        chk("miss_pulse", int'(miss_pulse), 2);
        chk("miss_count", int'(misses), 1);
        chk("miss_popped", int'(tile_valid[4]), 0);

        // Overflow on lane 3, then simultaneous 3-lane miss -> OVER
        do_reset();
        start_play();
        for (int i = 0; i < 5; i++) begin
            blk[2] = 1'b1;
            cycle();
            if (i == 3) chk("ovf_full", int'(tile_valid[11:8]), 15);
        end
        chk("ovf_miss", int'(misses), 1);
        chk("ovf_miss_pulse", int'(miss_pulse), 4);
        blk[0] = 1'b1; blk[1] = 1'b1;
        cycle();
        speed = 4'd15;
        ticks(31);
        chk("tri_miss_pulse", int'(miss_pulse), 7);
        chk("tri_misses", int'(misses), 3);
        chk("tri_go_early", int'(game_over), 0);
        cycle();
        chk("tri_game_over", int'(game_over), 1);
        blk[3] = 1'b1;
        cycle();
        chk("over_spawn_ignored", int'(tile_valid[15:12]), 0);
        chk("over_hold_lane3", int'(tile_valid[11:8]), 7);
        screen = 1'b1;
        cycle();
        cycle();
        chk("restart_valid", int'(tile_valid), 0);
        chk("restart_misses", int'(misses), 0);
        chk("restart_go", int'(game_over), 0);

        // Held key on lane 4: one judgement only
        do_reset();
        start_play();
        blk[3] = 1'b1;
        cycle();
        speed = 4'd4;
        ticks(105);
        chk("hold_y", int'(tile_y[129:120]), 420);
        kil[3] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            cnt += int'(hit_pulse[3]);
        end
        chk("hold_hits", cnt, 1);
        chk("hold_score", int'(score), 1);
        kil[3] = 1'b0;
        cycle();
        // Press with the tile out of zone
        blk[3] = 1'b1;
        cycle();
        ticks(50);
        chk("out_y", int'(tile_y[129:120]), 200);
        kil[3] = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("out_no_pop", int'(tile_valid[12]), 1);
        chk("out_penalty", int'(miss_pulse[3]), PEN);
        chk("out_no_hit", int'(hit_pulse[3]), 0);
        kil[3] = 1'b0;
        cycle();

        // Kill and tick in the same cycle with tile at y=440
        do_reset();
        start_play();
        blk[0] = 1'b1;
        cycle();
        speed = 4'd8;
        ticks(25);
        blk[0] = 1'b1;
        cycle();
        ticks(30);
        chk("same_y", int'(tile_y[9:0]), 440);
        kil[0] = 1'b1;
        cycle();
        cycle();
        frame_tick = 1'b1;
        cycle();
        chk("same_hit", int'(hit_pulse[0]), 1);
        chk("same_no_miss", int'(miss_pulse[0]), 0);
        chk("same_advance", int'(tile_y[9:0]), 248);
        chk("same_valid", int'(tile_valid[3:0]), 1);
        kil[0] = 1'b0;
        cycle();

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            Reset      = ($urandom % 700 == 0);
            screen     = game_over ? ($urandom % 8 == 0) : ($urandom % 300 == 0);
            speed      = 4'($urandom_range(0, 15));
            frame_tick = ($urandom % 3 == 0);
            for (int l = 0; l < 4; l++) begin
                blk[l] = ($urandom % 14 == 0);
                if ($urandom % 5 == 0) kil[l] = ~kil[l];
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tile_lane_tracker.md
# tile_lane_tracker

Consumes the per-lane spawn pulses (`block1`..`block4`), the key-press levels (`kill1`..`kill4`), `speed` and `screen` from the song state machine. Tracks up to four falling tiles per lane, moves them once per video frame, judges each key press against the hit zone and keeps score and miss counts. Its outputs feed the tile renderer and the score/HUD display.

## Interface
- `DEPTH`, 4: tile slots per lane (power of two)
- `HIT_TOP`, 10'd400: lowest tile-top y that counts as a hit (inclusive)
- `HIT_BOT`, 10'd440: highest tile-top y that counts as a hit (inclusive)
- `MISS_Y`, 10'd460: tile-top y at or beyond which a tile is missed
- `MAX_MISS`, 4'd3: miss count that ends the game
- `Clk`  in  1  frame-logic clock; one clock only
- `Reset`  in  1  synchronous, active-high
- `frame_tick`  in  1  one-cycle pulse per video frame (Clk domain)
- `screen`  in  1  1 = title screen; holds the block idle and cleared
- `block1`..`block4`  in  1 each  one-cycle spawn pulse for lane 1..4 (Clk domain)
- `kill1`..`kill4`  in  1 each  key-held levels, asynchronous to Clk
- `speed`  in  4  pixels per frame added to every tile y
- `tile_y`  out  4*DEPTH*10  tile-top y; lane L, slot S at bits [(L*DEPTH+S)*10 +: 10]
- `tile_valid`  out  4*DEPTH  slot occupancy, same indexing
- `hit_pulse`  out  4  one-cycle pulse per lane on a judged hit
- `miss_pulse`  out  4  one-cycle pulse per lane on a miss
- `score`  out  16  hit count, saturating
- `misses`  out  4  miss count, saturating at MAX_MISS
- `game_over`  out  1  high in OVER

## Operation
- Game FSM states IDLE, PLAY, OVER. IDLE→PLAY when `screen`=0. PLAY→OVER when `misses` reaches MAX_MISS. OVER→IDLE when `screen`=1. `screen`=1 in any state forces IDLE.
- IDLE clears all slots, `score` and `misses`. IDLE and OVER ignore spawn, kill and tick. OVER holds all slot contents.
- Each lane is an ordered FIFO; slot 0 holds the oldest tile.
- Spawn (PLAY): push y=0. If the lane is full and there is no pop that cycle, the spawn is dropped and counts as one miss on that lane.
- Tick (PLAY): every valid y += zero-extended `speed`, saturating at 10'h3FF. If the oldest updated y ≥ MISS_Y, pop it and assert `miss_pulse`. Only the oldest tile is checked on a given tick.
- Kill: 2-FF synchronizer, then rising-edge detect. On an edge, if the oldest tile is valid and HIT_TOP ≤ y ≤ HIT_BOT, pop it, assert `hit_pulse` and increment `score`. Otherwise there is no effect (but see Configuration).
- Same-cycle events on one lane: the kill is judged on the pre-tick y. A hit pop and a tick-miss pop cannot both occur; the hit takes precedence and the remaining tiles advance. Spawn plus pop in the same cycle are both applied (the pushed tile is not advanced that cycle).
- Multiple lanes missing in one cycle: `misses` increases by the number of lanes, saturating at MAX_MISS.

## Timing
- Reset values: FSM=IDLE, all `tile_valid`=0, `tile_y`=0, `score`=0, `misses`=0, `hit_pulse`=0, `miss_pulse`=0, `game_over`=0, synchronizer and edge flops=0.
- All outputs are registered.
- Spawn/tick effects are visible one cycle after the input pulse.
- `hit_pulse` asserts on the 3rd Clk edge after a `kill` rise is first sampled.
- Holding a key produces exactly one judgement; the level must fall and rise again for another.
- `Reset` mid-game overrides all events in that cycle.

## Configuration
- `TILE_MISS_PENALTY_EN` defined: a kill edge with no oldest tile inside the hit zone (empty lane or tile out of zone) asserts `miss_pulse` and counts as a miss. The tile is not popped.
- Undefined: such presses are ignored.

## Structure
- Package `tile_pkg`: `game_state_t` enum, `Y_W`=10, and default values for HIT_TOP/HIT_BOT/MISS_Y/DEPTH.
- Sub-module `tile_lane`, instantiated 4×. It contains the FIFO, tick advance, hit-zone compare and kill synchronizer/edge detect, and produces per-lane hit/miss pulses.
- The top holds the FSM, counters and output packing.

## Test plan
- Reset, `screen`=0, `block1` pulse, `speed`=4, then 100 ticks → lane 1 slot 0 y=400. Kill1 rise → `hit_pulse[0]` 3 cycles later, `score`=1, lane empty.
- Spawn lane 2, `speed`=5, 92 ticks with no key → `miss_pulse[1]` on the 92nd tick (y=460), `misses`=1.
- Five spawns on lane 3 with no ticks → 4 valid slots, 5th spawn gives `misses`=1. A 3-lane simultaneous miss at `misses`=1 → `misses`=3, `game_over`=1 next cycle; further spawns ignored.
- Kill4 held high for 50 cycles with tile at y=420 → exactly one hit. Kill4 rise with tile at y=200 → no pop; `miss_pulse[3]` only with TILE_MISS_PENALTY_EN.
- Tile at y=440, tick (speed=8) and kill edge landing in the same cycle → hit, no miss.
- In OVER, `screen`=1 → IDLE, all slots, `score` and `misses` cleared.
